// File: rtl/bcd_count_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_count_ctrl
//
// Run/pause controller for a cascade of decade (mod-10) digit counters.
// Owns start/stop/clear/load sequencing, a tick prescaler, BCD ripple carry
// between digits and a terminal-value compare against `target`.
//
// Parameters
//   DIGITS    number of decade digits (1..8)
//   TICK_DIV  clock cycles per count tick (>=1)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   start      enter/resume RUN (ignored while running)
//   stop       RUN -> PAUSE, prescaler held
//   clear      any state -> IDLE, count and prescaler zeroed
//   load       preset count from load_val (ignored while running)
//   load_val   BCD preset, digit 0 in [3:0]; nibbles >9 load as 0
//   target     BCD terminal value; any nibble >9 disables matching
//   bcd_out    current count (registered)
//   busy       high in RUN or PAUSE (registered state decode)
//   done       one-cycle pulse after the edge where the count becomes target
//   carry_out  one-cycle pulse after an all-9s -> all-0s wrap
//
// Command priority within one cycle: clear > load > stop > start. A command
// that does not apply in the current state is skipped and the next one is
// considered.
//
// Build option
//   BCD_CTRL_AUTORELOAD_EN  when defined, a match keeps the block in RUN and
//                           the following tick reloads 0 (period target+1
//                           ticks); DONE is then unreachable. Undefined: a
//                           match parks the block in DONE holding the count.
// -----------------------------------------------------------------------------
module bcd_count_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] target,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                busy,
  output logic                done,
  output logic                carry_out
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_p0, state_d;
  logic [W-1:0]    cnt_p0, cnt_d;
  logic [PW-1:0]   pre_p0, pre_d;
  logic            busy_d, done_d, carry_d;
  logic            tick;
  logic            match;
  logic [W-1:0]    nxt_cnt;
`ifdef BCD_CTRL_AUTORELOAD_EN
  // Set by a match; the next tick reloads 0 instead of incrementing.
  logic            pend_p0, pend_d;
`endif

  // Replace any non-decimal nibble with 0.
  function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'd0;
    end
    return r;
  endfunction

  // True when every nibble is a legal decimal digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // True when every digit is 9 (the next increment wraps the whole count).
  function automatic logic bcd_all_nines(input logic [W-1:0] v);
    logic all9;
    all9 = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] != 4'd9) all9 = 1'b0;
    end
    return all9;
  endfunction

  // Ripple-carry decimal increment: digit k moves only when all lower digits
  // were 9; a digit at 9 rolls to 0 and passes the carry up.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (v[4*d +: 4] >= 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick = (state_p0 == ST_RUN) && (pre_p0 == PRE_LAST);

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_p0;
    cnt_d   = cnt_p0;
    pre_d   = pre_p0;
    done_d  = 1'b0;
    carry_d = 1'b0;
    match   = 1'b0;
    nxt_cnt = bcd_inc(cnt_p0);
`ifdef BCD_CTRL_AUTORELOAD_EN
    pend_d  = pend_p0;
`endif

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pre_d   = '0;
`ifdef BCD_CTRL_AUTORELOAD_EN
      pend_d  = 1'b0;
`endif
    end else if (load && (state_p0 != ST_RUN)) begin
      cnt_d = bcd_sanitize(load_val);
`ifdef BCD_CTRL_AUTORELOAD_EN
      pend_d = 1'b0;
`endif
    end else if (stop && (state_p0 == ST_RUN)) begin
      // Prescaler is left untouched so a later start resumes mid-period.
      state_d = ST_PAUSE;
    end else if (start && (state_p0 != ST_RUN)) begin
      state_d = ST_RUN;
      if (state_p0 != ST_PAUSE) pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
`ifdef BCD_CTRL_AUTORELOAD_EN
      if (pend_p0) begin
        cnt_d = '0;
      end else begin
        cnt_d   = nxt_cnt;
        carry_d = bcd_all_nines(cnt_p0);
      end
      // Compare the value being loaded, so a count already at target when
      // started never matches before a full lap.
      match  = bcd_valid(target) && (cnt_d == target);
      done_d = match;
      pend_d = match;
`else
      cnt_d   = nxt_cnt;
      carry_d = bcd_all_nines(cnt_p0);
      match   = bcd_valid(target) && (cnt_d == target);
      done_d  = match;
      if (match) state_d = ST_DONE;
`endif
    end else if (state_p0 == ST_RUN) begin
      pre_d = pre_p0 + 1'b1;
    end
  end

  // Output decode: busy is registered from the next state so it lines up
  // with the state register.
  always_comb begin
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // ---- stage p0: state, count, prescaler and output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0  <= ST_IDLE;
      cnt_p0    <= '0;
      pre_p0    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
`ifdef BCD_CTRL_AUTORELOAD_EN
      pend_p0   <= 1'b0;
`endif
    end else begin
      state_p0  <= state_d;
      cnt_p0    <= cnt_d;
      pre_p0    <= pre_d;
      busy      <= busy_d;
      done      <= done_d;
      carry_out <= carry_d;
`ifdef BCD_CTRL_AUTORELOAD_EN
      pend_p0   <= pend_d;
`endif
    end
  end

  assign bcd_out = cnt_p0;

endmodule
